// File: rtl/tt_pkg.sv
// Shared types and elaboration-time helpers for the truth-table sweeper.
package tt_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    function automatic int nvec(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // A settle interval of 1 still needs a 1-bit counter.
    function automatic int settle_w(input int settle);
        return (clog2(settle) < 1) ? 1 : clog2(settle);
    endfunction

endpackage

// File: rtl/tt_settle_counter.sv
// Settle-interval timer: tc is high while the count sits at SETTLE-1.
// Combinational tc, one count per enabled cycle; clr takes priority over en.
module tt_settle_counter #(
    parameter int SETTLE = 2,
    parameter int W      = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [W-1:0] count;

    assign tc = (count == W'(SETTLE - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive N_IN-input truth-table sweeper/checker; TT_STOP_ON_FAIL_EN halts on the first mismatch.
// Each vector takes SETTLE+1 cycles; no backpressure, start is ignored while busy.
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int                      N_IN   = 3,
    parameter logic [(1<<N_IN)-1:0]    EXP_TT = 8'b1110_1000,
    parameter int                      SETTLE = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            f_in,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail,
    output logic            first_fail_valid
);

    localparam int              NV   = nvec(N_IN);
    localparam int              CW   = settle_w(SETTLE);
    localparam logic [N_IN-1:0] LAST = N_IN'(NV - 1);

    state_t state;
    logic   settle_tc;
    logic   launch;
    logic   mismatch;

    assign launch   = ((state == S_IDLE) || (state == S_DONE)) && start;
    assign mismatch = (f_in != EXP_TT[vec_out]);
    assign pass     = done && (err_count == '0);

    tt_settle_counter #(
        .SETTLE (SETTLE),
        .W      (CW)
    ) u_settle (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (launch || (state == S_SAMPLE)),
        .en      (state == S_SETTLE),
        .tc      (settle_tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            vec_out          <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err_count        <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state            <= S_SETTLE;
                        vec_out          <= '0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        err_count        <= '0;
                        first_fail       <= '0;
                        first_fail_valid <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (settle_tc) begin
                        state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    if (mismatch) begin
                        err_count <= err_count + (N_IN+1)'(1);
                        if (!first_fail_valid) begin
                            first_fail       <= vec_out;
                            first_fail_valid <= 1'b1;
                        end
                    end
`ifdef TT_STOP_ON_FAIL_EN
                    // vec_out stays on the failing vector so the board shows it.
                    if (mismatch || (vec_out == LAST)) begin
`else
                    if (vec_out == LAST) begin
`endif
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state   <= S_SETTLE;
                        vec_out <= vec_out + N_IN'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: cycle-by-cycle model check plus directed literal checks.
module tb_truth_table_sweeper;

    localparam int         N   = 3;
    localparam int         S   = 2;
    localparam int         P   = S + 1;
    localparam int         NV  = 8;
    localparam logic [7:0] EXP = 8'b1110_1000;

`ifdef TT_STOP_ON_FAIL_EN
    localparam int L_S2_CYC = 13;
    localparam int L_S2_ERR = 1;
    localparam int L_S2_VEC = 3;
`else
    localparam int L_S2_CYC = 25;
    localparam int L_S2_ERR = 4;
    localparam int L_S2_VEC = 7;
`endif

    typedef struct packed {
        logic [2:0] vec;
        logic       busy;
        logic       done;
        logic       pass;
        logic [3:0] err;
        logic [2:0] ff;
        logic       ffv;
    } obs_t;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       f_in;
    logic [2:0] vec_out;
    logic       busy, done, pass;
    logic [3:0] err_count;
    logic [2:0] first_fail;
    logic       first_fail_valid;

    logic       start2;
    logic       f2;
    logic [3:0] vec2;
    logic       busy2, done2, pass2;
    logic [4:0] err2;
    logic [3:0] ff2;
    logic       ffv2;

    int mode;
    int mode_lat;
    int phase;
    int t;
    int n_pass;
    int n_total;
    int cyc;

    truth_table_sweeper #(.N_IN(N), .EXP_TT(EXP), .SETTLE(S)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .f_in             (f_in),
        .vec_out          (vec_out),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_fail       (first_fail),
        .first_fail_valid (first_fail_valid)
    );

    truth_table_sweeper #(.N_IN(4), .EXP_TT(16'h8000), .SETTLE(2)) dut4 (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start2),
        .f_in             (f2),
        .vec_out          (vec2),
        .busy             (busy2),
        .done             (done2),
        .pass             (pass2),
        .err_count        (err2),
        .first_fail       (ff2),
        .first_fail_valid (ffv2)
    );

    // mode 0: 3-input majority, mode 1: output stuck at 0
    function automatic logic fmodel(input int md, input int v);
        logic [2:0] b;
        b = 3'(v);
        return (md == 0) ? ($countones(b) >= 2) : 1'b0;
    endfunction

    assign f_in = fmodel(mode, int'(vec_out));
    assign f2   = &vec2;

    function automatic logic mism(input int md, input int k);
        logic [7:0] tt;
        tt = EXP;
        return fmodel(md, k) != tt[k];
    endfunction

    // Expected outputs t cycles into a sweep (cycle 1 is the one after start is sampled).
    function automatic obs_t expect_at(input int tt_cyc, input int md);
        obs_t e;
        int   nv;
        int   tend;
        int   err;
        e   = '0;
        nv  = NV;
        err = 0;
`ifdef TT_STOP_ON_FAIL_EN
        for (int k = NV - 1; k >= 0; k--) if (mism(md, k)) nv = k + 1;
`endif
        tend = 1 + nv * P;
        if (tt_cyc < tend) begin
            e.busy = 1'b1;
            e.vec  = 3'((tt_cyc - 1) / P);
        end else begin
            e.done = 1'b1;
            e.vec  = 3'(nv - 1);
        end
        for (int k = 0; k < nv; k++) begin
            if (mism(md, k) && ((k + 1) * P + 1 <= tt_cyc)) begin
                err++;
                if (!e.ffv) begin
                    e.ff  = 3'(k);
                    e.ffv = 1'b1;
                end
            end
        end
        e.err  = 4'(err);
        e.pass = e.done && (err == 0);
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        obs_t cur;
        cur = expect_at(t, mode_lat);
        if (!reset_n) begin
            phase <= 0;
        end else if (start && (phase == 0 || cur.done)) begin
            phase    <= 1;
            t        <= 1;
            mode_lat <= mode;
        end else if (phase == 1) begin
            t <= t + 1;
        end
    end

    always @(negedge clk) begin
        obs_t e;
        obs_t o;
        o = {vec_out, busy, done, pass, err_count, first_fail, first_fail_valid};
        if (!reset_n || phase == 0) e = '0;
        else e = expect_at(t, mode_lat);
        chk("cycle_outputs", int'(o), int'(e));
    end

    task automatic run_sweep(input int extra, output int c);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        c = 1;
        while (!done && c < 200) begin
            @(negedge clk);
            c++;
            start = (c == extra);
        end
        start = 1'b0;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        phase = 0; t = 0; mode = 0; mode_lat = 0;
        start = 1'b0; start2 = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_err", int'(err_count), 0);
        chk("reset_busy_done", int'({busy, done, pass}), 0);
        @(negedge clk) reset_n = 1'b1;

        // majority DUT, clean sweep
        run_sweep(0, cyc);
        chk("s1_done_cycle", cyc, 25);
        chk("s1_pass", int'(pass), 1);
        chk("s1_err", int'(err_count), 0);
        chk("s1_ffv", int'(first_fail_valid), 0);
        chk("s1_vec", int'(vec_out), 7);

        // stuck-at-0 DUT
        mode = 1;
        run_sweep(0, cyc);
        chk("s2_done_cycle", cyc, L_S2_CYC);
        chk("s2_err", int'(err_count), L_S2_ERR);
        chk("s2_first_fail", int'(first_fail), 3);
        chk("s2_ffv", int'(first_fail_valid), 1);
        chk("s2_pass", int'(pass), 0);
        chk("s2_vec", int'(vec_out), L_S2_VEC);

        // restart from DONE with a fixed DUT
        repeat (3) @(negedge clk);
        chk("s5_hold_err", int'(err_count), L_S2_ERR);
        mode = 0;
        run_sweep(0, cyc);
        chk("s5_done_cycle", cyc, 25);
        chk("s5_err", int'(err_count), 0);
        chk("s5_pass", int'(pass), 1);

        // start pulse at cycle 10 of a running sweep is ignored
        run_sweep(10, cyc);
        chk("s3_done_cycle", cyc, 25);
        chk("s3_pass", int'(pass), 1);
        chk("s3_err", int'(err_count), 0);

        // reset mid-sweep aborts immediately
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (11) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("s4_async_vec", int'(vec_out), 0);
        chk("s4_async_busy", int'(busy), 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("s4_no_done", int'(done), 0);
        run_sweep(0, cyc);
        chk("s4_done_cycle", cyc, 25);
        chk("s4_pass", int'(pass), 1);

        // 4-input AND against 16'h8000
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        cyc = 1;
        while (!done2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("and4_done_cycle", cyc, 49);
        chk("and4_pass", int'(pass2), 1);
        chk("and4_err", int'(err2), 0);
        chk("and4_vec", int'(vec2), 15);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
